// File: rtl/ring_pkg.sv
// ---------------------------------------------------------------------------
// ring_pkg
// Shared constants, types and helpers for the ring renderer slice.
//   - RGB565 colour width and the BLACK pixel value
//   - OLED raster geometry (96 x 64 = 6144 pixels)
//   - breathing animation FSM state encoding
//   - sq8: square of a signed 8-bit distance component
// ---------------------------------------------------------------------------
package ring_pkg;

  localparam int RGB_W = 16;
  localparam logic [RGB_W-1:0] BLACK = 16'h0000;

  localparam int OLED_W   = 96;
  localparam int OLED_H   = 64;
  localparam int OLED_PIX = 6144;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GROW   = 2'd1,
    SHRINK = 2'd2
  } anim_state_e;

  // Square of a two's complement byte. The low 16 bits of the product of
  // the sign-extended operands are exact, and |v| <= 128 keeps the result
  // inside 15 bits.
  function automatic logic [14:0] sq8(input logic [7:0] v);
    return 15'({{8{v[7]}}, v} * {{8{v[7]}}, v});
  endfunction

endpackage

// File: rtl/ring_anim_fsm.sv
// ---------------------------------------------------------------------------
// ring_anim_fsm
// Breathing animation: sweeps a radius offset 0 -> ANIM_MAX -> 0 ... one
// step per anim_tick while anim_en is high. Dropping anim_en returns to IDLE
// with a zero offset on the next cycle, regardless of a concurrent tick.
// Ports:
//   clk25     in   pixel clock
//   reset     in   synchronous active-high reset
//   anim_en   in   enable animation
//   anim_tick in   one-cycle step pulse
//   anim_off  out  current radius offset (registered)
// ---------------------------------------------------------------------------
module ring_anim_fsm
  import ring_pkg::*;
#(
  parameter int RAD_W    = 7,
  parameter int ANIM_MAX = 8
) (
  input  logic             clk25,
  input  logic             reset,
  input  logic             anim_en,
  input  logic             anim_tick,
  output logic [RAD_W-1:0] anim_off
);

  localparam logic [RAD_W-1:0] OFF_TOP  = RAD_W'(ANIM_MAX - 1);
  localparam logic [RAD_W-1:0] OFF_ONE  = RAD_W'(1);
  localparam logic [RAD_W-1:0] OFF_ZERO = RAD_W'(0);

  anim_state_e      state_r;
  anim_state_e      state_nxt_s;
  logic [RAD_W-1:0] off_r;
  logic [RAD_W-1:0] off_nxt_s;

  // State and offset registers
  always_ff @(posedge clk25) begin
    if (reset) begin
      state_r <= IDLE;
      off_r   <= OFF_ZERO;
    end else begin
      state_r <= state_nxt_s;
      off_r   <= off_nxt_s;
    end
  end

  // Next-state logic: direction flips when the offset reaches either end
  always_comb begin
    state_nxt_s = state_r;
    if (!anim_en) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: state_nxt_s = GROW;
        GROW: begin
          if (anim_tick && (off_r == OFF_TOP)) state_nxt_s = SHRINK;
          else                                 state_nxt_s = GROW;
        end
        SHRINK: begin
          if (anim_tick && (off_r == OFF_ONE)) state_nxt_s = GROW;
          else                                 state_nxt_s = SHRINK;
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Output logic: next offset value
  always_comb begin
    off_nxt_s = off_r;
    if (!anim_en) begin
      off_nxt_s = OFF_ZERO;
    end else begin
      case (state_r)
        IDLE: off_nxt_s = OFF_ZERO;
        GROW: begin
          if (anim_tick) off_nxt_s = off_r + OFF_ONE;
          else           off_nxt_s = off_r;
        end
        SHRINK: begin
          if (anim_tick) off_nxt_s = off_r - OFF_ONE;
          else           off_nxt_s = off_r;
        end
        default: off_nxt_s = OFF_ZERO;
      endcase
    end
  end

  assign anim_off = off_r;

endmodule

// File: rtl/ring_renderer.sv
// ---------------------------------------------------------------------------
// ring_renderer
// Pipelined annulus shader for the OLED raster. A pixel index presented in
// one cycle produces its colour three cycles later, together with the index.
// Centre, radii (plus animation offset) and colour are latched with pixel 0
// so a frame is always drawn with one consistent configuration.
// Ports:
//   clk25           in   pixel clock
//   reset           in   synchronous active-high reset
//   pixel_index     in   raster index, row-major
//   center_x/_y     in   ring centre column / row
//   r_inner/r_outer in   inclusive radii
//   color_in        in   RGB565 ring colour
//   anim_en         in   enable breathing animation
//   anim_tick       in   animation step pulse
//   color           out  RGB565 colour of pixel_index_out
//   pixel_index_out out  pixel_index delayed by three cycles
// ---------------------------------------------------------------------------
module ring_renderer
  import ring_pkg::*;
#(
  parameter int WIDTH    = OLED_W,
  parameter int HEIGHT   = OLED_H,
  parameter int PIX_W    = 13,
  parameter int RAD_W    = 7,
  parameter int ANIM_MAX = 8
) (
  input  logic             clk25,
  input  logic             reset,
  input  logic [PIX_W-1:0] pixel_index,
  input  logic [6:0]       center_x,
  input  logic [5:0]       center_y,
  input  logic [RAD_W-1:0] r_inner,
  input  logic [RAD_W-1:0] r_outer,
  input  logic [RGB_W-1:0] color_in,
  input  logic             anim_en,
  input  logic             anim_tick,
  output logic [RGB_W-1:0] color,
  output logic [PIX_W-1:0] pixel_index_out
);

  localparam int PIPE = 3;
  localparam int SQ_W = 2 * (RAD_W + 1);

  logic [RAD_W-1:0]   anim_off_s;
  logic               frame_start_s;
  logic [6:0]         cx_cur_s;
  logic [5:0]         cy_cur_s;
  logic [6:0]         x_s;
  logic [6:0]         y_s;
  logic signed [7:0]  dx_s;
  logic signed [7:0]  dy_s;
  logic               oob_s;
  logic [SQ_W-1:0]    d2_ext_s;

  // Latched frame configuration
  logic [6:0]         cx_r;
  logic [5:0]         cy_r;
  logic [RAD_W:0]     rin_eff_r;
  logic [RAD_W:0]     rout_eff_r;
  logic [RGB_W-1:0]   col_pend_r;
  logic [SQ_W-1:0]    rin2_r;
  logic [SQ_W-1:0]    rout2_r;
  logic [RGB_W-1:0]   col_r;

  // Pipeline registers
  logic signed [7:0]  dx_r;
  logic signed [7:0]  dy_r;
  logic               oob1_r;
  logic               first1_r;
  logic [14:0]        d2_r;
  logic               oob2_r;
  logic [PIX_W-1:0]   idx_dly_r [0:PIPE-2];

  ring_anim_fsm #(
    .RAD_W    (RAD_W),
    .ANIM_MAX (ANIM_MAX)
  ) u_anim (
    .clk25     (clk25),
    .reset     (reset),
    .anim_en   (anim_en),
    .anim_tick (anim_tick),
    .anim_off  (anim_off_s)
  );

  // Stage-0 decode: pixel 0 sees the incoming centre, not the stale latch
  always_comb begin
    frame_start_s = (pixel_index == {PIX_W{1'b0}});
    if (frame_start_s) begin
      cx_cur_s = center_x;
      cy_cur_s = center_y;
    end else begin
      cx_cur_s = cx_r;
      cy_cur_s = cy_r;
    end
    x_s   = 7'(pixel_index % PIX_W'(WIDTH));
    y_s   = 7'(pixel_index / PIX_W'(WIDTH));
    dx_s  = $signed({1'b0, x_s}) - $signed({1'b0, cx_cur_s});
    dy_s  = $signed({1'b0, y_s}) - $signed({2'b00, cy_cur_s});
    oob_s = (pixel_index >= PIX_W'(WIDTH * HEIGHT));
  end

  // Frame latch. Squared radii and colour move to the compare stage one
  // cycle after pixel 0 is captured, i.e. exactly when pixel 0 reaches
  // stage 2, so the last pixels of the previous frame keep the old values.
  always_ff @(posedge clk25) begin
    if (reset) begin
      cx_r       <= 7'd0;
      cy_r       <= 6'd0;
      rin_eff_r  <= {(RAD_W+1){1'b0}};
      rout_eff_r <= {(RAD_W+1){1'b0}};
      col_pend_r <= BLACK;
      rin2_r     <= {SQ_W{1'b0}};
      rout2_r    <= {SQ_W{1'b0}};
      col_r      <= BLACK;
    end else begin
      if (frame_start_s) begin
        cx_r       <= center_x;
        cy_r       <= center_y;
        rin_eff_r  <= {1'b0, r_inner} + {1'b0, anim_off_s};
        rout_eff_r <= {1'b0, r_outer} + {1'b0, anim_off_s};
        col_pend_r <= color_in;
      end
      if (first1_r) begin
        rin2_r  <= {{(RAD_W+1){1'b0}}, rin_eff_r}  * {{(RAD_W+1){1'b0}}, rin_eff_r};
        rout2_r <= {{(RAD_W+1){1'b0}}, rout_eff_r} * {{(RAD_W+1){1'b0}}, rout_eff_r};
        col_r   <= col_pend_r;
      end
    end
  end

  // Stage 1: centre-relative coordinates
  always_ff @(posedge clk25) begin
    if (reset) begin
      dx_r     <= 8'sd0;
      dy_r     <= 8'sd0;
      oob1_r   <= 1'b0;
      first1_r <= 1'b0;
    end else begin
      dx_r     <= dx_s;
      dy_r     <= dy_s;
      oob1_r   <= oob_s;
      first1_r <= frame_start_s;
    end
  end

  // Stage 2: squared distance
  always_ff @(posedge clk25) begin
    if (reset) begin
      d2_r   <= 15'd0;
      oob2_r <= 1'b0;
    end else begin
      d2_r   <= sq8(dx_r) + sq8(dy_r);
      oob2_r <= oob1_r;
    end
  end

  // Index delay line for stages 1 and 2
  always_ff @(posedge clk25) begin
    if (reset) begin
      for (int i = 0; i < PIPE - 1; i++) idx_dly_r[i] <= {PIX_W{1'b0}};
    end else begin
      idx_dly_r[0] <= pixel_index;
      for (int i = 1; i < PIPE - 1; i++) idx_dly_r[i] <= idx_dly_r[i-1];
    end
  end

  // Zero-extended distance for comparison against squared radii
  always_comb begin
    d2_ext_s = SQ_W'(d2_r);
  end

  // Stage 3: annulus test and registered outputs
  always_ff @(posedge clk25) begin
    if (reset) begin
      color           <= BLACK;
      pixel_index_out <= {PIX_W{1'b0}};
    end else begin
      if (!oob2_r && (d2_ext_s >= rin2_r) && (d2_ext_s <= rout2_r)) color <= col_r;
      else                                                          color <= BLACK;
      pixel_index_out <= idx_dly_r[PIPE-2];
    end
  end

endmodule

// File: tb/tb_ring_renderer.sv
// ---------------------------------------------------------------------------
// tb_ring_renderer
// Self-checking bench for ring_renderer (ANIM_MAX = 2). A reference model
// evaluates the annulus rule per pixel from integer geometry with a
// per-frame configuration, and the breathing offset as a bouncing counter;
// expected colour/index pairs sit in a three-deep delay queue.
// ---------------------------------------------------------------------------
module tb_ring_renderer;
  import ring_pkg::*;

  localparam int AM = 2;

  logic        clk25 = 1'b0;
  logic        reset;
  logic [12:0] pixel_index;
  logic [6:0]  center_x;
  logic [5:0]  center_y;
  logic [6:0]  r_inner;
  logic [6:0]  r_outer;
  logic [15:0] color_in;
  logic        anim_en;
  logic        anim_tick;
  logic [15:0] color;
  logic [12:0] pixel_index_out;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int          m_cx, m_cy, m_rin2, m_rout2;
  logic [15:0] m_col;
  int          m_off, m_dir;
  logic [15:0] e_col [3];
  logic [12:0] e_idx [3];

  ring_renderer #(.ANIM_MAX(AM)) dut (
    .clk25           (clk25),
    .reset           (reset),
    .pixel_index     (pixel_index),
    .center_x        (center_x),
    .center_y        (center_y),
    .r_inner         (r_inner),
    .r_outer         (r_outer),
    .color_in        (color_in),
    .anim_en         (anim_en),
    .anim_tick       (anim_tick),
    .color           (color),
    .pixel_index_out (pixel_index_out)
  );

  always #5 clk25 = ~clk25;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic void model_step();
    int x, y, d, ri, ro;
    logic [15:0] c;
    if (reset) begin
      m_cx = 0; m_cy = 0; m_rin2 = 0; m_rout2 = 0; m_col = 16'h0000;
      m_off = 0; m_dir = 0;
      for (int k = 0; k < 3; k++) begin e_col[k] = 16'h0000; e_idx[k] = 13'd0; end
      return;
    end
    if (pixel_index == 13'd0) begin
      m_cx = int'(center_x); m_cy = int'(center_y);
      ri = int'(r_inner) + m_off; ro = int'(r_outer) + m_off;
      m_rin2 = ri * ri; m_rout2 = ro * ro; m_col = color_in;
    end
    if (int'(pixel_index) >= 96 * 64) begin
      c = 16'h0000;
    end else begin
      x = int'(pixel_index) % 96; y = int'(pixel_index) / 96;
      d = (x - m_cx) * (x - m_cx) + (y - m_cy) * (y - m_cy);
      c = (d >= m_rin2 && d <= m_rout2) ? m_col : 16'h0000;
    end
    e_col[2] = e_col[1]; e_col[1] = e_col[0]; e_col[0] = c;
    e_idx[2] = e_idx[1]; e_idx[1] = e_idx[0]; e_idx[0] = pixel_index;
    // breathing offset bounces between 0 and AM
    if (!anim_en) begin
      m_off = 0; m_dir = 0;
    end else if (m_dir == 0) begin
      m_dir = 1;
    end else if (anim_tick) begin
      m_off = m_off + m_dir;
      if (m_off == AM) m_dir = -1;
      else if (m_off == 0) m_dir = 1;
    end
  endfunction

  task automatic clk_step();
    @(posedge clk25);
    model_step();
    @(negedge clk25);
  endtask

  task automatic test_reset();
    reset = 1'b1; pixel_index = 13'd0; center_x = 7'd0; center_y = 6'd0;
    r_inner = 7'd0; r_outer = 7'd0; color_in = 16'h0000; anim_en = 1'b0; anim_tick = 1'b0;
    clk_step(); clk_step();
    n_checks++; if (color !== 16'h0000) begin n_errors++; $display("FAIL reset_color got=%h want=0000", color); end
    n_checks++; if (pixel_index_out !== 13'd0) begin n_errors++; $display("FAIL reset_idx got=%0d want=0", pixel_index_out); end
    n_checks++; if (dut.u_anim.off_r !== 7'd0) begin n_errors++; $display("FAIL reset_off got=%0d want=0", dut.u_anim.off_r); end
    n_checks++; if (dut.u_anim.state_r !== IDLE) begin n_errors++; $display("FAIL reset_state got=%0d want=IDLE", dut.u_anim.state_r); end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    center_x = 7'd48; center_y = 6'd32; r_inner = 7'd12; r_outer = 7'd14;
    color_in = 16'hF800; anim_en = 1'b0; anim_tick = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 6144; i++) begin
        logic [15:0] want; bit spot;
        pixel_index = 13'(i); clk_step();
        n_checks++;
        if (color !== e_col[2] || pixel_index_out !== e_idx[2]) begin
          n_errors++;
          $display("FAIL basic f=%0d in=%0d got color=%h idx=%0d want color=%h idx=%0d", f, i, color, pixel_index_out, e_col[2], e_idx[2]);
        end
        spot = 1'b1; want = 16'h0000;
        case (i - 2)
          3120: want = 16'h0000;
          3132: want = 16'hF800;
          3134: want = 16'hF800;
          3135: want = 16'h0000;
          default: spot = 1'b0;
        endcase
        if (spot) begin
          n_checks++;
          if (color !== want || pixel_index_out !== 13'(i - 2)) begin
            n_errors++;
            $display("FAIL basic_spot idx=%0d got color=%h idx=%0d want color=%h", i - 2, color, pixel_index_out, want);
          end
        end
      end
    end
  endtask

  task automatic test_midframe_change();
    r_outer = 7'd14;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 6144; i++) begin
        pixel_index = 13'(i);
        if (f == 0 && i == 3000) r_outer = 7'd20;
        clk_step();
        n_checks++;
        if (color !== e_col[2] || pixel_index_out !== e_idx[2]) begin
          n_errors++;
          $display("FAIL midframe f=%0d in=%0d got color=%h want=%h", f, i, color, e_col[2]);
        end
        if (i - 2 == 3135) begin
          n_checks++;
          if (color !== ((f == 0) ? 16'h0000 : 16'hF800)) begin
            n_errors++;
            $display("FAIL midframe_3135 f=%0d got=%h want=%h", f, color, (f == 0) ? 16'h0000 : 16'hF800);
          end
        end
      end
    end
  endtask

  task automatic test_degenerate();
    // inverted radii: frame 0 all black; zero radii near edge: frame 1 centre only
    for (int f = 0; f < 2; f++) begin
      if (f == 0) begin center_x = 7'd48; center_y = 6'd32; r_inner = 7'd20; r_outer = 7'd10; end
      else        begin center_x = 7'd5;  center_y = 6'd0;  r_inner = 7'd0;  r_outer = 7'd0;  end
      color_in = 16'h07E0;
      for (int i = 0; i < 6144; i++) begin
        pixel_index = 13'(i); clk_step();
        n_checks++;
        if (color !== e_col[2] || pixel_index_out !== e_idx[2]) begin
          n_errors++;
          $display("FAIL degenerate f=%0d in=%0d got color=%h want=%h", f, i, color, e_col[2]);
        end
        if (i >= 2) begin
          n_checks++;
          if (color !== ((f == 1 && i - 2 == 5) ? 16'h07E0 : 16'h0000)) begin
            n_errors++;
            $display("FAIL degenerate_px f=%0d idx=%0d got=%h", f, i - 2, color);
          end
        end
      end
    end
  endtask

  task automatic test_anim();
    int seen[$];
    int want_seq[5] = '{1, 2, 1, 0, 1};
    pixel_index = 13'd6144; anim_tick = 1'b0;
    n_checks++; if (dut.u_anim.off_r !== 7'd0) begin n_errors++; $display("FAIL anim_start got=%0d want=0", dut.u_anim.off_r); end
    anim_en = 1'b1;
    for (int c = 0; c < 61; c++) begin
      anim_tick = (c > 0 && c % 10 == 0);
      clk_step();
      n_checks++;
      if (dut.u_anim.off_r !== 7'(m_off) || color !== e_col[2]) begin
        n_errors++; $display("FAIL anim_off c=%0d got=%0d want=%0d", c, dut.u_anim.off_r, m_off);
      end
      if (anim_tick && c <= 50) seen.push_back(int'(dut.u_anim.off_r));
    end
    anim_tick = 1'b0;
    n_checks++; if (seen.size() != 5) begin n_errors++; $display("FAIL anim_seq_len got=%0d want=5", seen.size()); end
    for (int k = 0; k < 5 && k < seen.size(); k++) begin
      n_checks++;
      if (seen[k] != want_seq[k]) begin n_errors++; $display("FAIL anim_seq k=%0d got=%0d want=%0d", k, seen[k], want_seq[k]); end
    end
    // offset is 2 now; ring 12..14 drawn as 14..16
    center_x = 7'd48; center_y = 6'd32; r_inner = 7'd12; r_outer = 7'd14; color_in = 16'hF800;
    for (int i = 0; i < 6144; i++) begin
      pixel_index = 13'(i); anim_tick = (i > 0 && i % 10 == 0); clk_step();
      n_checks++;
      if (color !== e_col[2] || dut.u_anim.off_r !== 7'(m_off)) begin
        n_errors++; $display("FAIL anim_frame in=%0d got color=%h off=%0d want color=%h off=%0d", i, color, dut.u_anim.off_r, e_col[2], m_off);
      end
      if (i - 2 == 3134 || i - 2 == 3136) begin
        n_checks++;
        if (color !== 16'hF800) begin n_errors++; $display("FAIL anim_lit idx=%0d got=%h want=f800", i - 2, color); end
      end
    end
    anim_tick = 1'b0;
  endtask

  task automatic test_anim_drop();
    pixel_index = 13'd6144; anim_tick = 1'b1;
    for (int k = 0; k < 20 && m_off != AM; k++) clk_step();
    n_checks++;
    if (dut.u_anim.off_r !== 7'd2) begin n_errors++; $display("FAIL anim_reach2 got=%0d want=2", dut.u_anim.off_r); end
    anim_en = 1'b0; anim_tick = 1'b1;
    clk_step();
    anim_tick = 1'b0;
    n_checks++; if (dut.u_anim.off_r !== 7'd0) begin n_errors++; $display("FAIL anim_drop_off got=%0d want=0", dut.u_anim.off_r); end
    n_checks++; if (dut.u_anim.state_r !== IDLE) begin n_errors++; $display("FAIL anim_drop_state got=%0d want=IDLE", dut.u_anim.state_r); end
  endtask

  task automatic test_reset_midframe();
    center_x = 7'd30; center_y = 6'd20; r_inner = 7'd5; r_outer = 7'd9; color_in = 16'h07E0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 6144; i++) begin
        pixel_index = 13'(i);
        reset = (f == 0 && (i == 2000 || i == 2001));
        clk_step();
        n_checks++;
        if (color !== e_col[2] || pixel_index_out !== e_idx[2]) begin
          n_errors++; $display("FAIL rst_mid f=%0d in=%0d got color=%h idx=%0d want color=%h idx=%0d", f, i, color, pixel_index_out, e_col[2], e_idx[2]);
        end
        if (reset) begin
          n_checks++;
          if (color !== 16'h0000 || pixel_index_out !== 13'd0) begin
            n_errors++; $display("FAIL rst_active got color=%h idx=%0d want 0/0", color, pixel_index_out);
          end
        end else if (f == 0 && i > 2001) begin
          n_checks++;
          if (color !== 16'h0000) begin n_errors++; $display("FAIL rst_black in=%0d got=%h want=0000", i, color); end
        end
      end
    end
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      pixel_index = 13'($urandom_range(6144, 8191)); clk_step();
      n_checks++;
      if (color !== e_col[2] || pixel_index_out !== e_idx[2] || (k >= 2 && color !== 16'h0000)) begin
        n_errors++; $display("FAIL oob k=%0d got color=%h idx=%0d want idx=%0d", k, color, pixel_index_out, e_idx[2]);
      end
    end
  endtask

  task automatic test_random();
    anim_en = 1'b1;
    for (int f = 0; f < 2; f++) begin
      center_x = 7'($urandom_range(0, 127)); center_y = 6'($urandom_range(0, 63));
      r_inner  = 7'($urandom_range(0, 30));  r_outer  = 7'(32'(r_inner) + $urandom_range(0, 25));
      color_in = 16'($urandom);
      for (int i = 0; i < 6144; i++) begin
        pixel_index = 13'(i);
        anim_tick = ($urandom_range(0, 6) == 0);
        if ($urandom_range(0, 499) == 0) begin
          center_x = 7'($urandom); center_y = 6'($urandom);
          r_inner = 7'($urandom_range(0, 40)); r_outer = 7'($urandom_range(0, 60)); color_in = 16'($urandom);
        end
        clk_step();
        n_checks++;
        if (color !== e_col[2] || pixel_index_out !== e_idx[2]) begin
          n_errors++; $display("FAIL random f=%0d in=%0d got color=%h idx=%0d want color=%h idx=%0d", f, i, color, pixel_index_out, e_col[2], e_idx[2]);
        end
      end
    end
    anim_tick = 1'b0;
    for (int k = 0; k < 3; k++) begin
      pixel_index = 13'(6144 + k); clk_step();
      n_checks++;
      if (color !== e_col[2] || pixel_index_out !== e_idx[2]) begin
        n_errors++; $display("FAIL flush k=%0d got color=%h want=%h", k, color, e_col[2]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_midframe_change();
    test_degenerate();
    test_anim();
    test_anim_drop();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ring_renderer.md
Name: ring_renderer

Overview:
- Pipelined, parametrised ring (annulus) pixel shader for the 96x64 OLED raster.
- Fed by the OLED driver's pixel_index at clk25. Returns the colour for that pixel 3 cycles later, with a delayed index for alignment.
- Runtime-programmable centre, inner/outer radius and colour, latched once per frame so the image never tears.
- Optional "breathing" animation: an FSM sweeps a radius offset up and down on an external tick.

Parameters:
- WIDTH, 96, display columns
- HEIGHT, 64, display rows
- PIX_W, 13, pixel_index width (must satisfy 2^PIX_W >= WIDTH*HEIGHT)
- RAD_W, 7, radius/offset field width
- ANIM_MAX, 8, peak animation offset in pixels (>=1, < 2^RAD_W)
- PIPE, 3, fixed latency (documentation only; not overridable)

Ports:
- clk25  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- pixel_index  in  PIX_W  current raster index (row-major, x = idx%WIDTH, y = idx/WIDTH)
- center_x  in  7  ring centre column
- center_y  in  6  ring centre row
- r_inner  in  RAD_W  inner radius (inclusive)
- r_outer  in  RAD_W  outer radius (inclusive)
- color_in  in  16  RGB565 ring colour
- anim_en  in  1  enable breathing animation
- anim_tick  in  1  one-cycle pulse advancing animation by one step
- color  out  16  RGB565 pixel colour, aligned with pixel_index_out
- pixel_index_out  out  PIX_W  pixel_index delayed by 3 cycles

Behaviour:
- Single clock domain clk25. Synchronous, active-high reset.
- Reset values:
  - color=0, pixel_index_out=0.
  - All pipeline registers 0.
  - Latched config (cx, cy, rin2, rout2, col) = 0.
  - FSM=IDLE, anim_off=0.
- Frame latch: when pixel_index==0 enters stage 0, capture in the same cycle:
  - center_x, center_y, color_in;
  - rin_eff = r_inner+anim_off and rout_eff = r_outer+anim_off, each RAD_W+1 bits, no saturation;
  - rin2 = rin_eff^2 and rout2 = rout_eff^2, each 2*(RAD_W+1) bits.
  - Pixel 0 itself uses the new config. Inputs changing mid-frame have no effect until the next frame.
- Pipeline, all three stages advance every cycle, no stall:
  - S1: x=idx%WIDTH, y=idx/WIDTH. dx=x-cx, dy=y-cy as signed 8-bit. Flag oob = idx >= WIDTH*HEIGHT.
  - S2: d2 = dx*dx + dy*dy, 15-bit unsigned (max 95^2+63^2 = 12994).
  - S3: color = (!oob && d2>=rin2 && d2<=rout2) ? col : 16'h0000. pixel_index_out = idx from 3 cycles earlier.
- Degenerate cases:
  - rin_eff > rout_eff: whole frame black.
  - rin_eff = rout_eff = 0: only the centre pixel is lit.
  - A centre near an edge is legal; the ring is clipped by the raster.
- Animation FSM, states IDLE, GROW, SHRINK:
  - IDLE: anim_off held at 0. If anim_en=1, go to GROW next cycle.
  - GROW, on anim_tick: if anim_off==ANIM_MAX-1, set anim_off=ANIM_MAX and go to SHRINK; else anim_off+1.
  - SHRINK, on anim_tick: if anim_off==1, set anim_off=0 and go to GROW; else anim_off-1.
  - anim_en=0 in any state: go to IDLE and set anim_off=0 on the next cycle. This overrides a tick in the same cycle.
  - A tick and a frame latch in the same cycle: the latch uses the pre-tick anim_off.
- Reset mid-frame: output is black until the next pixel_index==0 relatches config. The pipeline refills within 3 cycles.

Decomposition:
- Package ring_pkg holds:
  - RGB565 width and BLACK constant;
  - OLED_W=96, OLED_H=64, OLED_PIX=6144;
  - FSM state encoding (IDLE=2'd0, GROW=2'd1, SHRINK=2'd2).
- One sub-module, ring_anim_fsm: owns the state register and anim_off. Ports clk25, reset, anim_en, anim_tick, anim_off.
- Raster pipeline and frame latch stay in ring_renderer.

Test Plan:
- Centre (48,32), rin=12, rout=14, colour 16'hF800, anim_en=0, full frame sweep:
  - idx 3120 (x=48, y=32; d2=0) -> color=0.
  - idx 3132 (x=60, d2=144) -> F800.
  - idx 3134 (d2=196) -> F800.
  - idx 3135 (d2=225) -> 0.
  - pixel_index_out = idx from 3 cycles earlier.
- Change r_outer to 20 at idx 3000 mid-frame:
  - idx 3135 still 0 this frame.
  - F800 from the next frame on.
- rin=20, rout=10 -> every pixel 0 for the whole frame.
- Animation, anim_en=1, ANIM_MAX=2, ticks every 10 cycles:
  - anim_off sequence 0,1,2,1,0,1.
  - Frame latched at anim_off=2 with rin=12, rout=14 -> idx 3134 (d2=196) lit and idx 3136 (x=64, d2=256) lit.
- anim_en dropped at anim_off=2 together with a tick -> next cycle IDLE, anim_off=0.
- Reset asserted mid-frame for 2 cycles:
  - color=0 and pixel_index_out=0 during reset.
  - Output stays black until the next pixel_index=0.
  - Out-of-range idx 6144..8191 -> color=0.
